pixel_array_readout: RTL and testbench

Frame readout sequencer for the digital pixel sensor array; reads back the codes that the pixels latched from the shared counter bus during conversion. On a START pulse it walks the array row by row: it drives a one-hot row read-enable, waits for the column bus to settle, captures the row, then streams the pixels one at a time over a valid/ready interface to the downstream output logic. It sits between the pixel array column bus and the sensor output port, and is active only after conversion has finished.

---
 rtl/pixel_array_readout.sv | 215 +++++++++++++++++++++
 tb/tb_pixel_array_readout.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_readout.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// pixel_array_readout
//
// Frame readout sequencer for the digital pixel sensor array. After conversion
// has finished, a start pulse walks the array row by row. For each row it:
//   1. asserts a one-hot row read-enable,
//   2. waits for the column bus to settle,
//   3. captures the whole row into a local buffer,
//   4. streams the pixels one per transfer over a valid/ready interface.
// Pixel codes are passed through unmodified.
//
// Ports
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   begin one frame readout (sampled only when idle)
//   row_select  out  one-hot row read-enable, all-zero when no row is read
//   col_data    in   column bus, column c on [c*BIT_DEPTH +: BIT_DEPTH]
//   out_data    out  current pixel code
//   out_valid   out  out_data/out_row/out_col/out_last are valid
//   out_ready   in   downstream accepts the current pixel
//   out_row     out  row index of the current pixel
//   out_col     out  column index of the current pixel
//   out_last    out  current pixel is the last of the frame
//   busy        out  high from start acceptance until done
//   done        out  one-cycle pulse after the final pixel transfer
// -----------------------------------------------------------------------------
module pixel_array_readout #(
    parameter int unsigned BIT_DEPTH     = 8,
    parameter int unsigned ROWS          = 2,
    parameter int unsigned COLUMNS       = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    // Derived widths; not meant to be overridden.
    parameter int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int unsigned CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic [ROWS-1:0]              row_select,
    input  logic [COLUMNS*BIT_DEPTH-1:0] col_data,
    output logic [BIT_DEPTH-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [RW-1:0]                out_row,
    output logic [CW-1:0]                out_col,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(COLUMNS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StStream,
        StFinish
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [ROWS-1:0]      row_select_q, row_select_d;
    logic [BIT_DEPTH-1:0] row_buf_q [COLUMNS];
    logic [BIT_DEPTH-1:0] row_buf_d [COLUMNS];
    logic [BIT_DEPTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [RW-1:0] row_inc;
    logic [CW-1:0] col_inc;
    logic          row_is_last;
    logic          col_is_last;

    assign row_inc     = row_q + 1'b1;
    assign col_inc     = col_q + 1'b1;
    assign row_is_last = (row_q == ROW_LAST);
    assign col_is_last = (col_q == COL_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        settle_d     = settle_q;
        row_select_d = row_select_q;
        row_buf_d    = row_buf_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        busy_d       = busy_q;
        done_d       = done_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    row_d        = '0;
                    row_select_d = ROWS'(1);
                    settle_d     = '0;
                    busy_d       = 1'b1;
                    state_d      = StSelect;
                end
            end

            StSelect: begin
                if (settle_q == SETTLE_LAST) begin
                    // Bus has settled: take the whole row in one go so later bus
                    // activity cannot disturb the pixels still to be streamed.
                    for (int c = 0; c < COLUMNS; c++) begin
                        row_buf_d[c] = col_data[c*BIT_DEPTH +: BIT_DEPTH];
                    end
                    row_select_d = '0;
                    col_d        = '0;
                    out_data_d   = col_data[0 +: BIT_DEPTH];
                    out_valid_d  = 1'b1;
                    out_last_d   = row_is_last && (COLUMNS == 1);
                    state_d      = StStream;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            StStream: begin
                // out_valid is always high here, so out_ready alone marks a transfer.
                if (out_ready) begin
                    if (!col_is_last) begin
                        col_d      = col_inc;
                        out_data_d = row_buf_q[col_inc];
                        out_last_d = row_is_last && (col_inc == COL_LAST);
                    end else if (!row_is_last) begin
                        out_valid_d  = 1'b0;
                        row_d        = row_inc;
                        row_select_d = ROWS'(1) << row_inc;
                        settle_d     = '0;
                        state_d      = StSelect;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StFinish;
                    end
                end
            end

            StFinish: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            settle_q     <= '0;
            row_select_q <= '0;
            for (int c = 0; c < COLUMNS; c++) begin
                row_buf_q[c] <= '0;
            end
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            settle_q     <= settle_d;
            row_select_q <= row_select_d;
            row_buf_q    <= row_buf_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign row_select = row_select_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pixel_array_readout.sv
`timescale 1ns / 1ps
// Bench for pixel_array_readout: two instances (default geometry, and a 3x3
// array with SETTLE_CYCLES=3) share start/ready/reset. Each instance has a
// frame model expressed as a queue of expected output slots.
module tb_pixel_array_readout;

    typedef struct {
        int kind;      // 0: row selected, 1: pixel offered, 2: done pulse
        int r;
        int c;
        bit last_sel;  // final settle cycle of the row: bus captured on leaving it
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        out_ready;
    logic        dir_mode;
    logic [63:0] dir_bus;

    int total = 0;
    int bad   = 0;

    // Per-instance outputs gathered for directed checks.
    logic [1:0]  o_valid, o_busy, o_done, o_last;
    logic [15:0] o_data;
    logic [7:0]  o_rs;
    logic [3:0]  o_row, o_col;

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && o_busy != 2'b00; i++) step();
        chk("wait idle", longint'(o_busy), 0);
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : g_inst
            localparam int unsigned S  = (g == 0) ? 1 : 3;
            localparam int unsigned R  = (g == 0) ? 2 : 3;
            localparam int unsigned C  = (g == 0) ? 2 : 3;
            localparam int unsigned RW = (R > 1) ? $clog2(R) : 1;
            localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

            logic [C*8-1:0] col_data;
            logic [R-1:0]   row_select;
            logic [7:0]     out_data;
            logic [RW-1:0]  out_row;
            logic [CW-1:0]  out_col;
            logic           out_valid, out_last, busy, done;

            slot_t      q[$];
            logic [7:0] cap [C];
            slot_t      s;
            int         e_rs, e_v, e_busy, e_done, e_last;

            pixel_array_readout #(
                .BIT_DEPTH    (8),
                .ROWS         (R),
                .COLUMNS      (C),
                .SETTLE_CYCLES(S)
            ) dut (
                .clk       (clk),
                .reset_n   (rst_n),
                .start     (start),
                .row_select(row_select),
                .col_data  (col_data),
                .out_data  (out_data),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .out_row   (out_row),
                .out_col   (out_col),
                .out_last  (out_last),
                .busy      (busy),
                .done      (done)
            );

            assign o_valid[g]       = out_valid;
            assign o_busy[g]        = busy;
            assign o_done[g]        = done;
            assign o_last[g]        = out_last;
            assign o_data[g*8 +: 8] = out_data;
            assign o_rs[g*4 +: 4]   = 4'(row_select);
            assign o_row[g*2 +: 2]  = 2'(out_row);
            assign o_col[g*2 +: 2]  = 2'(out_col);

            // Column bus driver: random every cycle unless a directed value is set.
            initial begin
                col_data = '0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (dir_mode && g == 0) col_data = dir_bus[C*8-1:0];
                    else for (int i = 0; i < C; i++) col_data[i*8 +: 8] = 8'($urandom);
                end
            end

            // Frame model: a started frame is the slot list
            // (S select slots + C pixel slots) per row, then one done slot.
            // Each edge retires one slot, except a pixel slot without ready.
            initial begin
                forever begin
                    @(posedge clk or negedge rst_n);
                    if (!rst_n) begin
                        q.delete();
                    end else if (q.size() == 0) begin
                        if (start) begin
                            for (int rr = 0; rr < R; rr++) begin
                                for (int kk = 0; kk < S; kk++)
                                    q.push_back('{kind: 0, r: rr, c: 0, last_sel: (kk == S - 1)});
                                for (int cc = 0; cc < C; cc++)
                                    q.push_back('{kind: 1, r: rr, c: cc, last_sel: 1'b0});
                            end
                            q.push_back('{kind: 2, r: 0, c: 0, last_sel: 1'b0});
                        end
                    end else if (!(q[0].kind == 1 && !out_ready)) begin
                        if (q[0].kind == 0 && q[0].last_sel)
                            for (int i = 0; i < C; i++) cap[i] = col_data[i*8 +: 8];
                        void'(q.pop_front());
                    end
                end
            end

            // Compare every cycle, away from the active edge.
            initial begin
                forever begin
                    @(negedge clk);
                    e_rs = 0; e_v = 0; e_busy = 0; e_done = 0; e_last = 0;
                    if (q.size() != 0) begin
                        s      = q[0];
                        e_busy = 1;
                        if (s.kind == 0) e_rs = 1 << s.r;
                        if (s.kind == 1) begin
                            e_v    = 1;
                            e_last = (s.r == R - 1 && s.c == C - 1) ? 1 : 0;
                        end
                        if (s.kind == 2) e_done = 1;
                    end
                    chk($sformatf("i%0d row_select", g), longint'(row_select), e_rs);
                    chk($sformatf("i%0d out_valid", g), longint'(out_valid), e_v);
                    chk($sformatf("i%0d busy", g), longint'(busy), e_busy);
                    chk($sformatf("i%0d done", g), longint'(done), e_done);
                    chk($sformatf("i%0d out_last", g), longint'(out_last), e_last);
                    if (e_v == 1) begin
                        chk($sformatf("i%0d out_data", g), longint'(out_data), longint'(cap[s.c]));
                        chk($sformatf("i%0d out_row", g), longint'(out_row), s.r);
                        chk($sformatf("i%0d out_col", g), longint'(out_col), s.c);
                    end
                end
            end
        end
    endgenerate

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int hold;

    initial begin
        rst_n     = 1'b0;
        start     = 1'($urandom);
        out_ready = 1'($urandom);
        dir_mode  = 1'b0;
        dir_bus   = '0;
        hold      = 0;

        // Reset values with random inputs.
        #3;
        chk("reset valid", longint'(o_valid), 0);
        chk("reset busy", longint'(o_busy), 0);
        chk("reset done", longint'(o_done), 0);
        chk("reset last", longint'(o_last), 0);
        chk("reset data", longint'(o_data), 0);
        chk("reset rs", longint'(o_rs), 0);
        chk("reset row", longint'(o_row), 0);
        chk("reset col", longint'(o_col), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            start     = 1'($urandom);
            out_ready = 1'($urandom);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) step();
        chk("idle after release", longint'(o_busy), 0);

        // Full frame with defaults, ready held high.
        dir_mode  = 1'b1;
        dir_bus   = 64'h2211;
        out_ready = 1'b1;
        step();
        start = 1'b1;
        step();               // E0
        start = 1'b0;
        chk("f0 busy", longint'(o_busy[0]), 1);
        chk("f0 rs", longint'(o_rs[3:0]), 4'b0001);
        chk("f0 valid", longint'(o_valid[0]), 0);
        step();               // E1: row 0 captured
        chk("f1 valid", longint'(o_valid[0]), 1);
        chk("f1 data", longint'(o_data[7:0]), 8'h11);
        chk("f1 row", longint'(o_row[1:0]), 0);
        chk("f1 col", longint'(o_col[1:0]), 0);
        chk("f1 last", longint'(o_last[0]), 0);
        chk("f1 rs", longint'(o_rs[3:0]), 0);
        step();               // E2
        dir_bus = 64'h4433;
        chk("f2 data", longint'(o_data[7:0]), 8'h22);
        chk("f2 col", longint'(o_col[1:0]), 1);
        chk("f2 last", longint'(o_last[0]), 0);
        step();               // E3: row gap
        chk("f3 valid", longint'(o_valid[0]), 0);
        chk("f3 rs", longint'(o_rs[3:0]), 4'b0010);
        step();               // E4
        chk("f4 data", longint'(o_data[7:0]), 8'h33);
        chk("f4 row", longint'(o_row[1:0]), 1);
        chk("f4 col", longint'(o_col[1:0]), 0);
        step();               // E5
        chk("f5 data", longint'(o_data[7:0]), 8'h44);
        chk("f5 col", longint'(o_col[1:0]), 1);
        chk("f5 last", longint'(o_last[0]), 1);
        step();               // E6
        chk("f6 done", longint'(o_done[0]), 1);
        chk("f6 valid", longint'(o_valid[0]), 0);
        chk("f6 last", longint'(o_last[0]), 0);
        chk("f6 busy", longint'(o_busy[0]), 1);
        step();               // E7
        chk("f7 done", longint'(o_done[0]), 0);
        chk("f7 busy", longint'(o_busy[0]), 0);

        // Backpressure mid-row.
        wait_idle();
        dir_bus = 64'h6655;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp valid", longint'(o_valid[0]), 1);
            chk("bp data", longint'(o_data[7:0]), 8'h55);
            chk("bp col", longint'(o_col[1:0]), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp resume data", longint'(o_data[7:0]), 8'h66);
        chk("bp resume col", longint'(o_col[1:0]), 1);

        // Reset while instance 0 streams row 1.
        wait_idle();
        dir_mode = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !(o_valid[0] && o_row[1:0] == 2'd1); i++) step();
        chk("reach row 1", longint'(o_row[1:0]), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid reset valid", longint'(o_valid[0]), 0);
        chk("mid reset busy", longint'(o_busy[0]), 0);
        chk("mid reset rs", longint'(o_rs[3:0]), 0);
        chk("mid reset data", longint'(o_data[7:0]), 0);
        chk("mid reset row", longint'(o_row[1:0]), 0);
        chk("mid reset col", longint'(o_col[1:0]), 0);
        chk("mid reset last", longint'(o_last[0]), 0);
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart rs", longint'(o_rs[3:0]), 4'b0001);
        wait_idle();

        // Start held high across whole frames.
        start = 1'b1;
        repeat (45) step();
        start = 1'b0;
        wait_idle();

        // Randomized traffic with occasional held start and reset pulses.
        for (int i = 0; i < 2500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (hold == 0 && $urandom_range(0, 15) == 0) hold = $urandom_range(1, 25);
            start = (hold > 0);
            if (hold > 0) hold--;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
